// File: rtl/prog_mem_loader.sv
// Program memory with a streamed loader and a single-cycle fetch port.
// A per-word written bitmap makes never-loaded (or cleared) words read as
// all-zero NOPs, so the storage array itself never needs a reset.
module prog_mem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              loading,
    output logic              load_err,
    output logic [ADDR_W:0]   loaded_words
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {RUN, LOAD} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  bitmap;
    logic [ADDR_W-1:0] wr_ptr;
    logic              accept;
    logic              ptr_at_end;

    // load_ready is a registered copy of (state == LOAD), so it qualifies acceptance directly
    always_comb begin
        accept     = load_valid && load_ready;
        ptr_at_end = (wr_ptr == ADDR_W'(DEPTH - 1));
    end

    // Storage array: written on accepted load words, intentionally not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= load_data;
        end
    end

    // Control FSM, bitmap, pointer/counter and registered fetch output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            bitmap       <= '0;
            wr_ptr       <= '0;
            loaded_words <= '0;
            instr        <= '0;
            instr_valid  <= 1'b0;
            load_err     <= 1'b0;
            load_ready   <= 1'b0;
            loading      <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            load_err    <= 1'b0;

            // Fetch sees pre-clear bitmap even when load_start fires in the same cycle
            if (state == RUN && fetch_en) begin
                instr       <= bitmap[fetch_addr] ? mem[fetch_addr] : '0;
                instr_valid <= 1'b1;
            end

            case (state)
                RUN: begin
                    if (load_start) begin
                        bitmap       <= '0;
                        wr_ptr       <= '0;
                        loaded_words <= '0;
                        state        <= LOAD;
                        load_ready   <= 1'b1;
                        loading      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        bitmap[wr_ptr] <= 1'b1;
                        wr_ptr         <= wr_ptr + ADDR_W'(1);
                        loaded_words   <= loaded_words + (ADDR_W + 1)'(1);
                        if (load_last || ptr_at_end) begin
                            state      <= RUN;
                            load_ready <= 1'b0;
                            loading    <= 1'b0;
                            load_err   <= !load_last;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 The block SHALL provide parameter ADDR_W, default 5, meaning the address width.
REQ-002 The block SHALL provide parameter DATA_W, default 8, meaning the instruction width.
REQ-003 The block SHALL provide localparam DEPTH = 2**ADDR_W, meaning the number of words.
REQ-004 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-006 The block SHALL have port fetch_en, input, 1, the fetch request.
REQ-007 The block SHALL have port fetch_addr, input, ADDR_W, the fetch address.
REQ-008 The block SHALL have port instr, output, DATA_W, the registered fetched instruction.
REQ-009 The block SHALL have port instr_valid, output, 1, a pulse qualifying instr.
REQ-010 The block SHALL have port load_start, input, 1, the request to begin a new program image.
REQ-011 The block SHALL have port load_valid, input, 1, qualifying load_data.
REQ-012 The block SHALL have port load_data, input, DATA_W, the program word.
REQ-013 The block SHALL have port load_last, input, 1, marking the final word of the image.
REQ-014 The block SHALL have port load_ready, output, 1, which is high when a load word can be accepted.
REQ-015 The block SHALL have port loading, output, 1, which is high while in state LOAD.
REQ-016 The block SHALL have port load_err, output, 1, a one-cycle pulse on overflow.
REQ-017 The block SHALL have port loaded_words, output, ADDR_W+1, the count of words in the current image.

Function
REQ-018 The block SHALL contain a DEPTH x DATA_W storage array plus a DEPTH-bit written bitmap, one bit per word.
REQ-019 The FSM SHALL have exactly two states, RUN and LOAD.
REQ-020 In RUN, load_start SHALL clear the bitmap, reset the write pointer and loaded_words to 0, and enter LOAD on the next cycle.
REQ-021 In LOAD, load_ready SHALL be 1; in RUN, load_ready SHALL be 0.
REQ-022 A word SHALL be accepted on a clock edge where load_valid and load_ready are both 1; the word SHALL be written at the write pointer, its bitmap bit set, and the pointer and loaded_words incremented.
REQ-023 A word accepted with load_last=1 SHALL be written, and the FSM SHALL return to RUN on the next cycle.
REQ-024 Acceptance of word DEPTH-1 without load_last SHALL write it, return the FSM to RUN, and pulse load_err for 1 cycle; loaded_words SHALL equal DEPTH.
REQ-025 load_start asserted in LOAD SHALL be ignored.
REQ-026 load_valid asserted in RUN SHALL be ignored, with no write.
REQ-027 Fetch SHALL have 1-cycle latency: fetch_en=1 with address A at edge N SHALL drive instr and set instr_valid=1 after edge N+1-1, i.e. registered at edge N and visible in cycle N+1.
REQ-028 instr SHALL equal mem[A] if bitmap[A]=1, else all zeros (NOP).
REQ-029 instr_valid SHALL be 0 in any cycle not following an accepted fetch; instr SHALL hold its last value when no fetch occurs.
REQ-030 fetch_en in LOAD SHALL be ignored: instr_valid=0 and instr unchanged.
REQ-031 fetch_en in the same cycle as load_start, in RUN, SHALL be served with the pre-clear contents.
REQ-032 fetch_addr SHALL be used unsigned; no out-of-range address exists.

Reset
REQ-033 While reset=1, regardless of clk, the block SHALL set state=RUN, the bitmap to all 0, the write pointer to 0, loaded_words=0, instr=0, instr_valid=0, load_err=0, load_ready=0, and loading=0.
REQ-034 The storage array SHALL not be reset; reads of any location SHALL return 0 after reset via the bitmap.
REQ-035 Reset during LOAD SHALL abort the load, and all locations SHALL subsequently read 0.

Verification
REQ-036 Scenario: reset, then fetch addresses 0, 8, 31 -> instr=0x00 with instr_valid=1 one cycle after each fetch.
REQ-037 Scenario: load 0x10, 0x20, 0x43 (last on the 3rd word), then fetch 0, 1, 2, 3 -> 0x10, 0x20, 0x43, 0x00; loaded_words=3; loading low after the last word.
REQ-038 Scenario: load 32 words 0x01..0x20 with no last -> load_err pulses 1 cycle after word 31, FSM in RUN, loaded_words=32, fetch 31 -> 0x20.
REQ-039 Scenario: load_valid held high through 2 idle cycles in RUN, then fetch 0 -> no write, instr=0x00.
REQ-040 Scenario: fetch_en during LOAD -> instr_valid stays 0; a second load_start mid-LOAD does not reset the pointer.
REQ-041 Scenario: reset asserted between clock edges after 2 words of a load -> outputs are at reset values immediately, and fetch 0 returns 0x00.
